// File: rtl/fht_sched_pkg.sv
// Shared types and index helpers for the FHT frame scheduler.
// A frame index maps to bank = idx[1:0] and bank address = idx >> 2.
package fht_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    UNLOAD
  } state_t;

  function automatic int unsigned frame_len(input int unsigned a_bit);
    return 32'd4 << a_bit;
  endfunction

  function automatic logic [1:0] idx_bank(input logic [31:0] idx);
    return idx[1:0];
  endfunction

  function automatic logic [31:0] idx_addr(input logic [31:0] idx);
    return idx >> 2;
  endfunction

endpackage

// File: rtl/fht_skid_fifo.sv
// Two-entry skid FIFO between the bank read port and the result stream.
// The head entry is never overwritten while it is presented, so output data holds under stall.
module fht_skid_fifo #(
  parameter int D_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D_BIT-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [D_BIT-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [D_BIT-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler: loads N samples into the four banks, runs fht_control once,
// then streams the N results out in index order through a skid FIFO.
module fht_frame_sched
  import fht_sched_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iEN,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic             oSEL_HOST,
  output logic [A_BIT-1:0] oBANK_ADDR,
  output logic [3:0]       oBANK_WE,
  output logic [D_BIT-1:0] oBANK_WDATA,
  input  logic [D_BIT-1:0] iBANK_RDATA,
  output logic [1:0]       oBANK_SEL,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  localparam int CW = A_BIT + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(frame_len(A_BIT) - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] out_cnt;
  logic          seen_busy;
  logic          rd_pend;
  logic          rd_done;
  logic          fifo_in_ready;
  logic [1:0]    fifo_count;
  logic          pop;
  logic          issue;
  logic [2:0]    free_slots;

  // A read may issue only if its data is guaranteed a FIFO slot when it lands
  // next cycle; counting this cycle's pop keeps a 1/cycle stream under ready.
  assign pop        = oOUT_VALID & iOUT_READY;
  assign free_slots = 3'd2 - {1'b0, fifo_count} + {2'b00, pop};
  assign issue      = (state == UNLOAD) && !rd_done && (fifo_in_ready || pop) &&
                      (free_slots > {2'b00, rd_pend});
  assign cnt_nxt    = cnt + CW'(1);

  fht_skid_fifo #(
    .D_BIT(D_BIT)
  ) u_skid (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .in_data  (iBANK_RDATA),
    .in_valid (rd_pend),
    .in_ready (fifo_in_ready),
    .out_data (oOUT_DATA),
    .out_valid(oOUT_VALID),
    .out_ready(iOUT_READY),
    .count    (fifo_count)
  );

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state       <= IDLE;
      cnt         <= '0;
      out_cnt     <= '0;
      seen_busy   <= 1'b0;
      rd_pend     <= 1'b0;
      rd_done     <= 1'b0;
      oREADY      <= 1'b0;
      oFHT_START  <= 1'b0;
      oSEL_HOST   <= 1'b0;
      oBANK_ADDR  <= '0;
      oBANK_WE    <= '0;
      oBANK_WDATA <= '0;
      oBANK_SEL   <= '0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oBANK_WE    <= '0;
      oFHT_START  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      rd_pend     <= issue;
      case (state)
        IDLE: begin
          oSEL_HOST <= 1'b1;
          if (iEN) begin
            state  <= LOAD;
            cnt    <= '0;
            oREADY <= 1'b1;
            oBUSY  <= 1'b1;
          end
        end
        LOAD: begin
          if (iVALID && oREADY) begin
            oBANK_WE    <= 4'b0001 << idx_bank(32'(cnt));
            oBANK_ADDR  <= A_BIT'(idx_addr(32'(cnt)));
            oBANK_WDATA <= iDATA;
            if (cnt == LAST_IDX) begin
              state  <= START;
              cnt    <= '0;
              oREADY <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        // Host keeps the banks through START so the final registered write lands.
        START: begin
          state      <= RUN;
          oFHT_START <= 1'b1;
          oSEL_HOST  <= 1'b0;
          seen_busy  <= 1'b0;
        end
        RUN: begin
          if (!iFHT_RDY) begin
            seen_busy <= 1'b1;
          end
          if (iFHT_RDY && seen_busy) begin
            state      <= UNLOAD;
            oSEL_HOST  <= 1'b1;
            cnt        <= '0;
            out_cnt    <= '0;
            rd_done    <= 1'b0;
            oBANK_ADDR <= '0;
            oBANK_SEL  <= '0;
          end
        end
        UNLOAD: begin
          if (issue) begin
            if (cnt == LAST_IDX) begin
              rd_done <= 1'b1;
            end else begin
              cnt        <= cnt_nxt;
              oBANK_ADDR <= A_BIT'(idx_addr(32'(cnt_nxt)));
              oBANK_SEL  <= idx_bank(32'(cnt_nxt));
            end
          end
          if (pop) begin
            if (out_cnt == LAST_IDX) begin
              state       <= IDLE;
              oFRAME_DONE <= 1'b1;
              oBUSY       <= 1'b0;
              out_cnt     <= '0;
              cnt         <= '0;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Scoreboard bench for fht_frame_sched with N=16: random streams in, FHT and bank models,
// accepted samples queued as expected results and popped by a separate output monitor.
module tb_fht_frame_sched;

  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int N     = 16;

  logic             iCLK;
  logic             iRESET;
  logic             iEN;
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             oSEL_HOST;
  logic [A_BIT-1:0] oBANK_ADDR;
  logic [3:0]       oBANK_WE;
  logic [D_BIT-1:0] oBANK_WDATA;
  logic [D_BIT-1:0] iBANK_RDATA;
  logic [1:0]       oBANK_SEL;
  logic [D_BIT-1:0] oOUT_DATA;
  logic             oOUT_VALID;
  logic             iOUT_READY;
  logic             oBUSY;
  logic             oFRAME_DONE;

  fht_frame_sched #(
    .A_BIT(A_BIT),
    .D_BIT(D_BIT)
  ) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iEN        (iEN),
    .iDATA      (iDATA),
    .iVALID     (iVALID),
    .oREADY     (oREADY),
    .oFHT_START (oFHT_START),
    .iFHT_RDY   (iFHT_RDY),
    .oSEL_HOST  (oSEL_HOST),
    .oBANK_ADDR (oBANK_ADDR),
    .oBANK_WE   (oBANK_WE),
    .oBANK_WDATA(oBANK_WDATA),
    .iBANK_RDATA(iBANK_RDATA),
    .oBANK_SEL  (oBANK_SEL),
    .oOUT_DATA  (oOUT_DATA),
    .oOUT_VALID (oOUT_VALID),
    .iOUT_READY (iOUT_READY),
    .oBUSY      (oBUSY),
    .oFRAME_DONE(oFRAME_DONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks;
  int errors;
  logic [D_BIT-1:0] exp_q[$];
  int load_idx;
  int frames_done;
  int starts;
  int cyc;
  bit fht_rose;
  int unsigned vpct;
  int unsigned rpct;
  bit idx_data;
  bit thru;
  logic [D_BIT-1:0] mem [4][4];

  initial begin
    checks = 0; errors = 0; load_idx = 0; frames_done = 0; starts = 0; cyc = 0;
    vpct = 100; rpct = 30; idx_data = 1'b1; thru = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Bank RAMs: host writes when selected, one-cycle registered read through oBANK_SEL.
  always @(posedge iCLK) begin
    if (oSEL_HOST) begin
      for (int b = 0; b < 4; b++) begin
        if (oBANK_WE[b]) mem[b][oBANK_ADDR] <= oBANK_WDATA;
      end
    end
    iBANK_RDATA <= mem[oBANK_SEL][oBANK_ADDR];
  end

  // Input stream and downstream ready drivers.
  initial begin
    iVALID = 1'b0; iDATA = '0; iOUT_READY = 1'b0;
    forever begin
      @(posedge iCLK); #1;
      iVALID     = ($urandom_range(0, 99) < vpct);
      iDATA      = idx_data ? 16'(load_idx) : 16'($urandom);
      iOUT_READY = ($urandom_range(0, 99) < rpct);
    end
  end

  // fht_control model: stays ready two cycles after start, then busy for a while (identity transform).
  initial begin
    int busy_len;
    busy_len = 40;
    iFHT_RDY = 1'b1;
    fht_rose = 1'b0;
    forever begin
      @(posedge iCLK); #1;
      if (oFHT_START) begin
        fht_rose = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        iFHT_RDY = 1'b0;
        repeat (busy_len) @(posedge iCLK);
        #1;
        iFHT_RDY = 1'b1;
        fht_rose = 1'b1;
        busy_len = $urandom_range(5, 20);
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  initial begin
    bit prev_hs, in_run, first_pend, prev_stall;
    int prev_idx, last_hs_cyc, unload_cyc, out_idx, done_cyc, first_acc;
    logic [D_BIT-1:0] prev_data, stall_data;
    prev_hs = 0; in_run = 0; first_pend = 0; prev_stall = 0;
    prev_idx = 0; last_hs_cyc = -100; unload_cyc = 0; out_idx = 0; done_cyc = -1; first_acc = 0;
    prev_data = '0; stall_data = '0;
    forever begin
      @(negedge iCLK);
      cyc++;
      if (!iRESET) begin
        prev_hs = 0; in_run = 0; first_pend = 0; prev_stall = 0;
        out_idx = 0; done_cyc = -1; last_hs_cyc = -100;
        exp_q.delete();
        load_idx = 0;
        continue;
      end
      if (prev_hs || oBANK_WE != 4'b0000) begin
        check("bank_we", oBANK_WE, prev_hs ? (64'd1 << (prev_idx % 4)) : 64'd0);
        if (prev_hs) begin
          check("bank_addr", oBANK_ADDR, prev_idx / 4);
          check("bank_wdata", oBANK_WDATA, prev_data);
          check("sel_host_write", oSEL_HOST, 1);
        end
      end
      prev_hs = iVALID && oREADY;
      if (prev_hs) begin
        check("busy_in_load", oBUSY, 1);
        prev_idx  = load_idx;
        prev_data = iDATA;
        exp_q.push_back(iDATA);
        load_idx++;
        if (load_idx == N) begin
          load_idx    = 0;
          last_hs_cyc = cyc;
        end
      end
      if (oFHT_START) begin
        starts++;
        check("start_latency", cyc - last_hs_cyc, 2);
        check("sel_host_start", oSEL_HOST, 0);
        in_run = 1;
      end else if (in_run) begin
        if (oSEL_HOST) begin
          check("unload_after_rdy", fht_rose, 1);
          in_run     = 0;
          unload_cyc = cyc;
          first_pend = 1;
        end else begin
          check("ready_in_run", oREADY, 0);
        end
      end
      if (prev_stall) begin
        check("hold_valid", oOUT_VALID, 1);
        check("hold_data", oOUT_DATA, stall_data);
      end
      if (oOUT_VALID) begin
        if (first_pend) begin
          check("unload_latency", cyc - unload_cyc, 2);
          first_pend = 0;
        end
        if (iOUT_READY) begin
          check("result_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("result_data", oOUT_DATA, exp_q.pop_front());
          if (out_idx == 0) first_acc = cyc;
          out_idx++;
          if (out_idx == N) begin
            out_idx  = 0;
            done_cyc = cyc + 1;
            if (thru) check("throughput", cyc - first_acc, N - 1);
          end
        end
      end
      prev_stall = oOUT_VALID && !iOUT_READY;
      stall_data = oOUT_DATA;
      if (oFRAME_DONE || cyc == done_cyc) begin
        check("frame_done", {oFRAME_DONE, cyc == done_cyc}, 2'b11);
        if (oFRAME_DONE) frames_done++;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(posedge iCLK);
      k++;
    end
    check("frame_timeout", frames_done >= n, 1);
  endtask

  initial begin
    int k;
    iRESET = 1'b0;
    iEN    = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("reset_outputs", {oREADY, oFHT_START, oSEL_HOST, oBANK_ADDR, oBANK_WE, oBANK_WDATA,
                            oBANK_SEL, oOUT_DATA, oOUT_VALID, oBUSY, oFRAME_DONE}, 0);
    @(negedge iCLK);
    iRESET = 1'b1;
    @(posedge iCLK); #1;
    check("idle_sel_host", oSEL_HOST, 1);
    check("idle_not_busy", {oBUSY, oREADY}, 0);

    // Frame interrupted by reset partway through LOAD.
    iEN = 1'b1;
    k = 0;
    while (load_idx < 7 && k < 200) begin
      @(posedge iCLK);
      k++;
    end
    check("midload_reached", load_idx >= 7, 1);
    #2;
    iRESET = 1'b0;
    #1;
    check("midload_reset_outputs", {oREADY, oFHT_START, oSEL_HOST, oBANK_ADDR, oBANK_WE, oBANK_WDATA,
                                    oBANK_SEL, oOUT_DATA, oOUT_VALID, oBUSY, oFRAME_DONE}, 0);
    repeat (2) @(negedge iCLK);
    iRESET = 1'b1;

    // Frame 1: data = idx, valid held high, ready 30%.
    wait_frames(1, 3000);
    // Frame 2: random data and valid, ready held high.
    vpct = 60; idx_data = 1'b0; rpct = 100; thru = 1'b1;
    wait_frames(2, 3000);
    // Frame 3: enable dropped once the transform has started.
    vpct = 70; rpct = 50; thru = 1'b0;
    k = 0;
    while (starts < 3 && k < 3000) begin
      @(posedge iCLK);
      k++;
    end
    iEN = 1'b0;
    wait_frames(3, 3000);
    repeat (20) @(posedge iCLK);
    #1;
    check("idle_after_en_low", {oBUSY, oREADY}, 0);
    check("frames_done", frames_done, 3);
    check("start_pulses", starts, 3);
    check("scoreboard_empty", exp_q.size(), 0);
    check("no_accept_outside_load", load_idx, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
